// File: rtl/fpu_result_buffer.sv
// fpu_result_buffer: circular FIFO for FPU results that accrues sticky exception flags on each push.
module fpu_result_buffer #(
    parameter int WIDTH     = 16,
    parameter int TAG_WIDTH = 1,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_result,
    input  logic [4:0]                   in_status,
    input  logic [TAG_WIDTH-1:0]         in_tag,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_result,
    output logic [4:0]                   out_status,
    output logic [TAG_WIDTH-1:0]         out_tag,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [4:0]                   fflags,
    input  logic                         fflags_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0]     mem_result [DEPTH];
    logic [4:0]           mem_status [DEPTH];
    logic [TAG_WIDTH-1:0] mem_tag    [DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic                 push, pop;

    assign in_ready   = count < FULL;
    assign out_valid  = count != '0;
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign out_result = mem_result[rd_ptr];
    assign out_status = mem_status[rd_ptr];
    assign out_tag    = mem_tag[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_result[wr_ptr] <= in_result;
            mem_status[wr_ptr] <= in_status;
            mem_tag[wr_ptr]    <= in_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop) count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // A push discarded by flush contributes no flags; flush itself never clears them.
    always_ff @(posedge clk) begin
        if (rst) fflags <= '0;
        else if (fflags_clr) fflags <= (push && !flush) ? in_status : 5'b0;
        else if (push && !flush) fflags <= fflags | in_status;
    end
endmodule

// File: tb/tb_fpu_result_buffer.sv
// tb_fpu_result_buffer: directed scenario tests for fpu_result_buffer.
module tb_fpu_result_buffer;
    logic        clk = 0;
    logic        rst = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [15:0] in_result = '0;
    logic [4:0]  in_status = '0;
    logic [0:0]  in_tag = '0;
    logic        flush = 0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [15:0] out_result;
    logic [4:0]  out_status;
    logic [0:0]  out_tag;
    logic [2:0]  count;
    logic [4:0]  fflags;
    logic        fflags_clr = 0;
    int          tests = 0;
    int          fails = 0;

    fpu_result_buffer #(.WIDTH(16), .TAG_WIDTH(1), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_status(in_status), .in_tag(in_tag),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_status(out_status), .out_tag(out_tag),
        .count(count), .fflags(fflags), .fflags_clr(fflags_clr)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [15:0] r, input logic [4:0] s, input logic t);
        in_valid = 1; in_result = r; in_status = s; in_tag = t;
        step();
        in_valid = 0; in_status = '0;
    endtask

    task automatic test_reset;
        rst = 1; step(); rst = 0;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
        tests++; if (fflags !== 5'b0) begin fails++; $display("FAIL reset_fflags got %b want 00000", fflags); end
    endtask

    task automatic test_single;
        push_one(16'h3C00, 5'b00001, 1'b1);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %b want 1", out_valid); end
        tests++; if (out_result !== 16'h3C00) begin fails++; $display("FAIL single_result got %h want 3c00", out_result); end
        tests++; if (out_status !== 5'b00001) begin fails++; $display("FAIL single_status got %b want 00001", out_status); end
        tests++; if (out_tag !== 1'b1) begin fails++; $display("FAIL single_tag got %b want 1", out_tag); end
        tests++; if (count !== 3'd1) begin fails++; $display("FAIL single_count got %0d want 1", count); end
        tests++; if (fflags !== 5'b00001) begin fails++; $display("FAIL single_fflags got %b want 00001", fflags); end
        out_ready = 1; step(); out_ready = 0;
        tests++; if (count !== 3'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL single_pop count %0d valid %b want 0 0", count, out_valid); end
    endtask

    task automatic test_fill;
        for (int i = 1; i <= 4; i++) push_one(16'(i), 5'b0, 1'(i));
        tests++; if (count !== 3'd4) begin fails++; $display("FAIL fill_count got %0d want 4", count); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL fill_in_ready got %b want 0", in_ready); end
        push_one(16'h0005, 5'b0, 1'b0);
        tests++; if (count !== 3'd4 || out_result !== 16'h0001) begin fails++; $display("FAIL full_no_push count %0d head %h want 4 0001", count, out_result); end
        in_valid = 1; in_result = 16'h0005; out_ready = 1;
        step();
        in_valid = 0;
        tests++; if (count !== 3'd3) begin fails++; $display("FAIL full_pop_count got %0d want 3", count); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL full_pop_in_ready got %b want 1", in_ready); end
        for (int i = 2; i <= 4; i++) begin
            tests++; if (out_result !== 16'(i) || out_tag !== 1'(i)) begin fails++; $display("FAIL drain_%0d got %h/%b want %h/%b", i, out_result, out_tag, 16'(i), 1'(i)); end
            step();
        end
        tests++; if (count !== 3'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL drain_empty count %0d valid %b want 0 0", count, out_valid); end
        step();
        out_ready = 0;
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL underflow count got %0d want 0", count); end
    endtask

    task automatic test_back_to_back;
        push_one(16'hA000, 5'b0, 1'b0);
        push_one(16'hA001, 5'b0, 1'b1);
        out_ready = 1; in_valid = 1;
        for (int k = 0; k < 6; k++) begin
            in_result = 16'hA002 + 16'(k); in_tag = 1'(k);
            tests++; if (out_result !== 16'hA000 + 16'(k)) begin fails++; $display("FAIL b2b_head_%0d got %h want %h", k, out_result, 16'hA000 + 16'(k)); end
            step();
            tests++; if (count !== 3'd2) begin fails++; $display("FAIL b2b_count_%0d got %0d want 2", k, count); end
        end
        in_valid = 0;
        for (int k = 6; k < 8; k++) begin
            tests++; if (out_result !== 16'hA000 + 16'(k)) begin fails++; $display("FAIL b2b_drain_%0d got %h want %h", k, out_result, 16'hA000 + 16'(k)); end
            step();
        end
        out_ready = 0;
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL b2b_end_count got %0d want 0", count); end
    endtask

    task automatic test_flush;
        fflags_clr = 1; step(); fflags_clr = 0;
        push_one(16'h0101, 5'b00001, 1'b0);
        push_one(16'h0102, 5'b00010, 1'b0);
        push_one(16'h0103, 5'b01000, 1'b0);
        tests++; if (count !== 3'd3) begin fails++; $display("FAIL flush_pre_count got %0d want 3", count); end
        flush = 1; in_valid = 1; in_result = 16'h0104; in_status = 5'b0;
        step();
        flush = 0; in_valid = 0;
        tests++; if (count !== 3'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL flush_empty count %0d valid %b want 0 0", count, out_valid); end
        tests++; if (fflags !== 5'b01011) begin fails++; $display("FAIL flush_fflags got %b want 01011", fflags); end
        push_one(16'h00F0, 5'b0, 1'b1);
        tests++; if (out_result !== 16'h00F0 || count !== 3'd1) begin fails++; $display("FAIL flush_repush head %h count %0d want 00f0 1", out_result, count); end
        out_ready = 1; step(); out_ready = 0;
    endtask

    task automatic test_flags;
        fflags_clr = 1; step(); fflags_clr = 0;
        push_one(16'h0201, 5'b10000, 1'b0);
        tests++; if (fflags !== 5'b10000) begin fails++; $display("FAIL flags_nv got %b want 10000", fflags); end
        fflags_clr = 1;
        push_one(16'h0202, 5'b00100, 1'b0);
        tests++; if (fflags !== 5'b00100) begin fails++; $display("FAIL flags_clr_push got %b want 00100", fflags); end
        step();
        fflags_clr = 0;
        tests++; if (fflags !== 5'b00000) begin fails++; $display("FAIL flags_clr got %b want 00000", fflags); end
        tests++; if (count !== 3'd2 || out_status !== 5'b10000) begin fails++; $display("FAIL flags_entries count %0d status %b want 2 10000", count, out_status); end
        flush = 1; step(); flush = 0;
    endtask

    task automatic test_reset_mid;
        push_one(16'h0301, 5'b00001, 1'b0);
        push_one(16'h0302, 5'b00010, 1'b0);
        tests++; if (count !== 3'd2 || fflags !== 5'b00011) begin fails++; $display("FAIL mid_pre count %0d fflags %b want 2 00011", count, fflags); end
        rst = 1; step(); rst = 0;
        tests++; if (count !== 3'd0 || fflags !== 5'b0) begin fails++; $display("FAIL mid_rst count %0d fflags %b want 0 00000", count, fflags); end
        tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_hs in_ready %b out_valid %b want 1 0", in_ready, out_valid); end
        push_one(16'h0BEE, 5'b0, 1'b0);
        tests++; if (out_result !== 16'h0BEE || count !== 3'd1) begin fails++; $display("FAIL mid_repush head %h count %0d want 0bee 1", out_result, count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_flush();
        test_flags();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fpu_result_buffer.md
FPU_RESULT_BUFFER -- requirements
Module: fpu_result_buffer

Interface
REQ-001 Parameters SHALL be: WIDTH, 16, result width (matches FPU WIDTH); TAG_WIDTH, 1, tag width; DEPTH, 4, entries (power of 2, >=2).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 in_valid  in  1  FPU result valid (driven by FPU out_valid).
REQ-005 in_ready  out  1  buffer can accept (drives FPU out_ready).
REQ-006 in_result  in  WIDTH  FPU result.
REQ-007 in_status  in  5  FPU status {NV,DZ,OF,UF,NX}, bit 4 = NV, bit 0 = NX.
REQ-008 in_tag  in  TAG_WIDTH  FPU tag.
REQ-009 flush  in  1  discard all buffered entries.
REQ-010 out_valid  out  1  head entry valid.
REQ-011 out_ready  in  1  consumer accepts head.
REQ-012 out_result, out_status, out_tag  out  WIDTH/5/TAG_WIDTH  head entry fields.
REQ-013 count  out  $clog2(DEPTH+1)  current occupancy.
REQ-014 fflags  out  5  sticky accrued exception flags.
REQ-015 fflags_clr  in  1  clear sticky flags.

Function
REQ-016 Storage SHALL be a circular FIFO of DEPTH entries {result,status,tag}, with write pointer, read pointer and count registers.
REQ-017 Push SHALL occur iff in_valid && in_ready; pop SHALL occur iff out_valid && out_ready.
REQ-018 in_ready SHALL equal (count < DEPTH), registered-state only, with no combinational path from out_ready.
REQ-019 out_valid SHALL equal (count != 0); out_* SHALL show the entry at the read pointer and hold stable while out_valid && !out_ready.
REQ-020 Latency SHALL be 1 cycle: data pushed at edge N is visible on out_* from edge N onward; there is no bypass of empty storage.
REQ-021 Push only: count+1 and write pointer advances; pop only: count-1 and read pointer advances; both: count unchanged and both pointers advance.
REQ-022 Pointers SHALL wrap modulo DEPTH (DEPTH-1 -> 0).
REQ-023 When full, in_ready=0 and no push SHALL occur even if out_ready=1 in the same cycle; the pop proceeds, and in_ready=1 next cycle.
REQ-024 When empty, out_ready SHALL be ignored; count never underflows.
REQ-025 Entries SHALL be delivered in push order, with result, status and tag of each entry kept together.
REQ-026 flush=1 SHALL set count, write pointer and read pointer to 0 at the next edge; any push or pop that cycle is discarded. fflags is not affected by flush.
REQ-027 On each push, fflags SHALL update to fflags | in_status.
REQ-028 fflags_clr=1 SHALL set fflags to 0; if a push happens in the same cycle, fflags SHALL become in_status, so the new flags are not lost.
REQ-029 Flags of entries later flushed SHALL remain accrued, because accrual happens at push.
REQ-030 Entry storage contents SHALL have no reset requirement; only control state and fflags are reset.

Reset
REQ-031 While rst=1 at an edge, count=0, pointers=0 and fflags=0; rst has priority over flush, fflags_clr and push/pop.
REQ-032 After reset, outputs SHALL be in_ready=1, out_valid=0, count=0, fflags=0.
REQ-033 Reset asserted mid-operation SHALL discard all entries, and the next push after reset SHALL appear at the head.

Verification
REQ-034 Single pass: push {result=16'h3C00, status=5'b00001, tag=1} with out_ready=0 -> next cycle out_valid=1, out_result=16'h3C00, count=1, fflags=5'b00001.
REQ-035 Fill/full: push 4 entries 16'h0001..16'h0004 with out_ready=0 -> count=4, in_ready=0; a 5th in_valid is not accepted; out_ready=1 -> pops 0001..0004 in order, and in_ready=1 the cycle after the first pop.
REQ-036 Simultaneous: count=2 with in_valid=1 and out_ready=1 for 6 cycles -> count stays 2, order preserved across pointer wrap.
REQ-037 Flush: count=3 with flush=1 and in_valid=1 -> next cycle count=0, out_valid=0; fflags keeps all bits OR-ed from the 3 prior pushes.
REQ-038 Flags: push status 5'b10000, then fflags_clr=1 together with a push of status 5'b00100 -> fflags=5'b00100; fflags_clr alone -> 5'b00000.
REQ-039 Reset mid-stream: count=2 and fflags=5'b00011, then rst=1 for one cycle -> count=0, fflags=0, in_ready=1, out_valid=0.
